// File: rtl/mdu_ctrl_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies and op-class helpers.
// Also used by CU decode and the hazard unit; MDU_MADD_EN widens the mult class to madd/msub.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8,
    MD_MADD  = 4'd9,
    MD_MADDU = 4'd10,
    MD_MSUB  = 4'd11,
    MD_MSUBU = 4'd12
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;
  localparam int unsigned DEF_CNT_W       = 4;

  function automatic logic is_mult_class(input logic [3:0] op);
    logic res;
    case (op)
      MD_MULT, MD_MULTU: res = 1'b1;
`ifdef MDU_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    logic res;
    case (op)
      MD_DIV, MD_DIVU: res = 1'b1;
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_md_class(input logic [3:0] op);
    return is_mult_class(op) | is_div_class(op);
  endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// mdu_calc: combinational HI/LO result for mult/div (and madd/msub under MDU_MADD_EN).
// Divide by zero returns the current HI/LO so the commit leaves them unchanged.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] sprod_s;
  logic [63:0] uprod_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] sdiv_b_s;
  logic [31:0] udiv_b_s;
  logic [31:0] q_mag_s;
  logic [31:0] r_mag_s;
  logic [31:0] sq_s;
  logic [31:0] sr_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic        div_zero_s;

  // Products, magnitude-based signed divide and result selection
  always_comb begin
    sprod_s    = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    uprod_s    = {32'd0, rs_val} * {32'd0, rt_val};
    div_zero_s = (rt_val == 32'd0);

    // Magnitudes keep 0x80000000 / -1 well defined (quotient wraps to 0x80000000)
    abs_a_s  = rs_val[31] ? (32'd0 - rs_val) : rs_val;
    abs_b_s  = rt_val[31] ? (32'd0 - rt_val) : rt_val;
    sdiv_b_s = div_zero_s ? 32'd1 : abs_b_s;
    udiv_b_s = div_zero_s ? 32'd1 : rt_val;
    q_mag_s  = abs_a_s / sdiv_b_s;
    r_mag_s  = abs_a_s % sdiv_b_s;
    sq_s     = (rs_val[31] ^ rt_val[31]) ? (32'd0 - q_mag_s) : q_mag_s;
    sr_s     = rs_val[31] ? (32'd0 - r_mag_s) : r_mag_s;
    uq_s     = rs_val / udiv_b_s;
    ur_s     = rs_val % udiv_b_s;

    case (op)
      MD_MULT:  {res_hi, res_lo} = sprod_s;
      MD_MULTU: {res_hi, res_lo} = uprod_s;
      MD_DIV: begin
        if (div_zero_s) begin
          {res_hi, res_lo} = {hi, lo};
        end else begin
          {res_hi, res_lo} = {sr_s, sq_s};
        end
      end
      MD_DIVU: begin
        if (div_zero_s) begin
          {res_hi, res_lo} = {hi, lo};
        end else begin
          {res_hi, res_lo} = {ur_s, uq_s};
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD:  {res_hi, res_lo} = {hi, lo} + sprod_s;
      MD_MADDU: {res_hi, res_lo} = {hi, lo} + uprod_s;
      MD_MSUB:  {res_hi, res_lo} = {hi, lo} - sprod_s;
      MD_MSUBU: {res_hi, res_lo} = {hi, lo} - uprod_s;
`endif
      default:  {res_hi, res_lo} = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: computes at issue, holds Busy for the op latency, commits HI/LO.
// Define MDU_MADD_EN to accept madd/maddu/msub/msubu.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  mdu_state_e       state_r;
  mdu_state_e       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      temp_hi_r;
  logic [31:0]      temp_lo_r;
  logic [31:0]      calc_hi_s;
  logic [31:0]      calc_lo_s;

  mdu_calc u_calc (
    .op     (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi_r),
    .lo     (lo_r),
    .res_hi (calc_hi_s),
    .res_lo (calc_lo_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: issue on Start, finish when the countdown reaches one
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs: hazard handshake and mf read port
  always_comb begin
    Busy   = (state_r == ST_RUN);
    Start  = is_md_class(md_op) && !Req && (state_r == ST_IDLE);
    md_out = 32'd0;
    case (md_op)
      MD_MFHI: md_out = hi_r;
      MD_MFLO: md_out = lo_r;
      default: md_out = 32'd0;
    endcase
  end

  // Datapath: temp capture at issue, countdown, commit, mthi/mtlo
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= '0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      temp_hi_r <= 32'd0;
      temp_lo_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            temp_hi_r <= calc_hi_s;
            temp_lo_r <= calc_lo_s;
            cnt_r     <= is_div_class(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (!Req && (md_op == MD_MTHI)) begin
            hi_r <= rs_val;
          end else if (!Req && (md_op == MD_MTLO)) begin
            lo_r <= rs_val;
          end else begin
            cnt_r <= '0;
          end
        end
        ST_RUN: begin
          if (cnt_r == CNT_W'(1)) begin
            hi_r  <= temp_hi_r;
            lo_r  <= temp_lo_r;
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  assign HI = hi_r;
  assign LO = lo_r;

endmodule
